// File: rtl/riscv_mem_arbiter_if.sv
// Request/response bundle between the icache/dcache miss paths, the arbiter and backing memory.
// The slave view belongs to the arbiter; the master view is the surrounding requesters and memory.
interface riscv_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              ic_req_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_req_ready;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_wdata;
    logic [MASK_W-1:0] dc_req_wmask;
    logic              dc_req_ready;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between icache and dcache misses.
// dcache has priority; icache is forced after STARVE_MAX dcache grants made while it waited.
module riscv_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    riscv_mem_arbiter_if.slave bus,
    output logic               busy
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  starve_cnt;
    logic              owner_dc;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic              ic_resp_valid_q;
    logic              dc_resp_valid_q;
    logic [DATA_W-1:0] ic_resp_data_q;
    logic [DATA_W-1:0] dc_resp_data_q;

    logic starved;
    logic grant_ic;
    logic grant_dc;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are gated by reset so the ready outputs stay low while reset is held.
    always_comb begin
        state_next = state;
        grant_ic   = 1'b0;
        grant_dc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset) begin
                    if (bus.ic_req_valid && (starved || !bus.dc_req_valid)) begin
                        grant_ic = 1'b1;
                    end else if (bus.dc_req_valid) begin
                        grant_dc = 1'b1;
                    end
                    if (grant_ic || grant_dc) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt      <= '0;
            owner_dc        <= 1'b0;
            rw_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_data_q  <= '0;
        end else begin
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;

            if (grant_ic) begin
                owner_dc   <= 1'b0;
                rw_q       <= 1'b0;
                addr_q     <= bus.ic_req_addr;
                wdata_q    <= '0;
                wmask_q    <= '0;
                starve_cnt <= '0;
            end else if (grant_dc) begin
                owner_dc <= 1'b1;
                rw_q     <= bus.dc_req_rw;
                addr_q   <= bus.dc_req_addr;
                wdata_q  <= bus.dc_req_wdata;
                wmask_q  <= bus.dc_req_wmask;
                if (bus.ic_req_valid && !starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end

            // Responses outside WAIT are stray and dropped.
            if (state == WAIT && bus.mem_resp_valid) begin
                if (owner_dc) begin
                    dc_resp_valid_q <= 1'b1;
                    dc_resp_data_q  <= rw_q ? '0 : bus.mem_resp_data;
                end else begin
                    ic_resp_valid_q <= 1'b1;
                    ic_resp_data_q  <= bus.mem_resp_data;
                end
            end
        end
    end

    assign bus.ic_req_ready  = grant_ic;
    assign bus.dc_req_ready  = grant_dc;
    assign bus.ic_resp_valid = ic_resp_valid_q;
    assign bus.ic_resp_data  = ic_resp_data_q;
    assign bus.dc_resp_valid = dc_resp_valid_q;
    assign bus.dc_resp_data  = dc_resp_data_q;

    assign bus.mem_req_valid = (state == ISSUE);
    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;

    assign busy = (state != IDLE);
endmodule
